// File: rtl/riscv_pkg.sv
// Shared RV32I writeback definitions: load funct3 encodings and the
// register-file write request carried through the writeback FIFO.
package riscv_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;
endpackage

// File: rtl/load_extend.sv
// Load data extraction: picks the addressed byte/halfword from the raw
// memory word and sign/zero-extends it according to the load funct3.
module load_extend
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] ext
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    // offset[0] is ignored for halfwords; misalignment traps upstream
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  ext = {24'd0, byte_sel};
      F3_LH:   ext = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  ext = {16'd0, half_sel};
      default: ext = word;
    endcase
  end
endmodule

// File: rtl/wb_unit.sv
// Writeback unit: merges load returns and ALU results onto the single
// register-file write port; blocked ALU results wait in an in-order FIFO.
module wb_unit
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [4:0]                 alu_rd,
  input  logic [31:0]                alu_data,
  input  logic                       lsu_valid,
  input  logic [4:0]                 lsu_rd,
  input  logic [2:0]                 lsu_funct3,
  input  logic [1:0]                 lsu_addr,
  input  logic [31:0]                lsu_rdata,
  output logic [4:0]                 rd,
  output logic [31:0]                DataWr,
  output logic                       RUWr,
  output logic [$clog2(DEPTH):0]     pending
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_req_t        fifo [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [CW-1:0]  cnt;
  logic [31:0]    ld_data;
  logic           load_sel, fifo_ne, alu_live, push, pop, sel_vld;
  wb_req_t        sel;

  load_extend u_ext (
    .funct3 (lsu_funct3),
    .offset (lsu_addr),
    .word   (lsu_rdata),
    .ext    (ld_data)
  );

  // Ready comes only from registered occupancy: a same-cycle pop never reopens it.
  assign alu_ready = (cnt != CW'(DEPTH));
  assign pending   = cnt;

  always_comb begin
    load_sel = lsu_valid && (lsu_rd != 5'd0);
    fifo_ne  = (cnt != '0);
    alu_live = alu_valid && alu_ready && (alu_rd != 5'd0);
    pop      = !load_sel && fifo_ne;
    push     = alu_live && (load_sel || fifo_ne);
    sel_vld  = load_sel || fifo_ne || alu_live;
    if (load_sel)     sel = '{rd: lsu_rd, data: ld_data};
    else if (fifo_ne) sel = fifo[rptr];
    else              sel = '{rd: alu_rd, data: alu_data};
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wptr] <= '{rd: alu_rd, data: alu_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      RUWr   <= 1'b0;
      rd     <= 5'd0;
      DataWr <= 32'd0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      cnt  <= cnt + CW'(push) - CW'(pop);
      RUWr <= sel_vld;
      if (sel_vld) begin
        rd     <= sel.rd;
        DataWr <= sel.data;
      end
    end
  end
endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed scenarios plus random traffic
// compared against a queue-based reference of the writeback rules.
module tb_wb_unit;
  import riscv_pkg::*;
  localparam int DEPTH = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        alu_valid = 1'b0, alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_valid = 1'b0;
  logic [4:0]  lsu_rd = '0;
  logic [2:0]  lsu_funct3 = '0;
  logic [1:0]  lsu_addr = '0;
  logic [31:0] lsu_rdata = '0;
  logic [4:0]  rd;
  logic [31:0] DataWr;
  logic        RUWr;
  logic [$clog2(DEPTH):0] pending;

  wb_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_funct3(lsu_funct3),
    .lsu_addr(lsu_addr), .lsu_rdata(lsu_rdata),
    .rd(rd), .DataWr(DataWr), .RUWr(RUWr), .pending(pending)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_bad = 0;
  wb_req_t     q[$];
  logic        e_wr = 1'b0;
  logic [4:0]  e_rd = '0;
  logic [31:0] e_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [1:0] a,
                                          input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [2:0] lf3,
                       input logic [1:0] la, input logic [31:0] lw);
    alu_valid = av; alu_rd = ard; alu_data = adat;
    lsu_valid = lv; lsu_rd = lrd; lsu_funct3 = lf3; lsu_addr = la; lsu_rdata = lw;
  endtask

  // One clock: check ready, advance the reference, clock, then check outputs.
  task automatic cyc(output logic acc);
    wb_req_t r;
    logic    live;
    #1;
    check("alu_ready", 32'(alu_ready), 32'(q.size() != DEPTH));
    acc  = alu_valid && (q.size() != DEPTH);
    live = acc && (alu_rd != 0);
    if (lsu_valid && lsu_rd != 0) begin
      e_wr = 1'b1; e_rd = lsu_rd; e_data = ref_ext(lsu_funct3, lsu_addr, lsu_rdata);
      if (live) q.push_back('{rd: alu_rd, data: alu_data});
    end else if (q.size() > 0) begin
      r = q.pop_front();
      e_wr = 1'b1; e_rd = r.rd; e_data = r.data;
      if (live) q.push_back('{rd: alu_rd, data: alu_data});
    end else if (live) begin
      e_wr = 1'b1; e_rd = alu_rd; e_data = alu_data;
    end else begin
      e_wr = 1'b0;
    end
    @(posedge clk);
    #1;
    check("RUWr", 32'(RUWr), 32'(e_wr));
    check("rd", 32'(rd), 32'(e_rd));
    check("DataWr", DataWr, e_data);
    check("pending", 32'(pending), 32'(q.size()));
  endtask

  task automatic idle();
    logic a;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(a);
  endtask

  initial begin
    logic        a;
    int          nxt, acc_cnt, guard;
    logic [4:0]  order[$];

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check("rst_RUWr", 32'(RUWr), 0);
    check("rst_rd", 32'(rd), 0);
    check("rst_DataWr", DataWr, 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_ready", 32'(alu_ready), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU bypass
    drive(1, 5'd5, 32'hAABBCCDD, 0, 0, 0, 0, 0);
    cyc(a);
    check("byp_rd", 32'(rd), 5);
    check("byp_data", DataWr, 32'hAABBCCDD);
    check("byp_pend", 32'(pending), 0);
    idle();

    // Load/ALU collision
    drive(1, 5'd3, 32'h12345678, 1, 5'd7, F3_LB, 2'd2, 32'h0080FF11);
    cyc(a);
    check("col_rd1", 32'(rd), 7);
    check("col_data1", DataWr, 32'hFFFFFF80);
    check("col_pend1", 32'(pending), 1);
    idle();
    check("col_rd2", 32'(rd), 3);
    check("col_data2", DataWr, 32'h12345678);
    check("col_pend2", 32'(pending), 0);
    idle();

    // Back-pressure: four loads while ALU x1..x3 are offered
    nxt = 1; acc_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive(nxt <= 3, 5'(nxt), 32'h100 + nxt, 1, 5'(20 + i), F3_LW, 0, 32'hC0DE0000 + i);
      cyc(a);
      if (a) begin nxt++; acc_cnt++; end
    end
    check("bp_accepted", acc_cnt, 2);
    check("bp_ready_low", 32'(alu_ready), 0);
    guard = 0;
    while ((nxt <= 3 || q.size() > 0 || RUWr) && guard < 20) begin
      drive(nxt <= 3, 5'(nxt), 32'h100 + nxt, 0, 0, 0, 0, 0);
      cyc(a);
      if (a) nxt++;
      if (RUWr && rd >= 1 && rd <= 3) order.push_back(rd);
      guard++;
    end
    check("bp_guard", 32'(guard < 20), 1);
    check("bp_nwr", order.size(), 3);
    for (int i = 0; i < 3 && i < order.size(); i++) check("bp_order", 32'(order[i]), i + 1);

    // Extension matrix
    drive(0, 0, 0, 1, 5'd9, F3_LBU, 2'd0, 32'h8001F0FE); cyc(a); check("ext_lbu", DataWr, 32'h000000FE);
    drive(0, 0, 0, 1, 5'd9, F3_LH,  2'd2, 32'h8001F0FE); cyc(a); check("ext_lh",  DataWr, 32'hFFFF8001);
    drive(0, 0, 0, 1, 5'd9, F3_LHU, 2'd0, 32'h8001F0FE); cyc(a); check("ext_lhu", DataWr, 32'h0000F0FE);
    drive(0, 0, 0, 1, 5'd9, F3_LW,  2'd0, 32'h8001F0FE); cyc(a); check("ext_lw",  DataWr, 32'h8001F0FE);
    drive(0, 0, 0, 1, 5'd9, 3'b111, 2'd1, 32'h8001F0FE); cyc(a); check("ext_f7",  DataWr, 32'h8001F0FE);
    idle();

    // x0 filtering, then a real request keeps 1-cycle latency
    drive(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, F3_LW, 0, 32'h11111111);
    cyc(a);
    check("x0_RUWr", 32'(RUWr), 0);
    check("x0_pend", 32'(pending), 0);
    drive(1, 5'd6, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    cyc(a);
    check("x0_next_wr", 32'(RUWr), 1);
    check("x0_next_data", DataWr, 32'hDEADBEEF);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 40, 5'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom);
      cyc(a);
    end

    // Reset mid-stream while RUWr is high and the FIFO is occupied
    drive(1, 5'd4, 32'h44444444, 1, 5'd8, F3_LW, 0, 32'h88888888);
    cyc(a);
    drive(1, 5'd5, 32'h55555555, 1, 5'd9, F3_LW, 0, 32'h99999999);
    cyc(a);
    check("mid_RUWr_pre", 32'(RUWr), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_RUWr", 32'(RUWr), 0);
    check("mid_rd", 32'(rd), 0);
    check("mid_DataWr", DataWr, 0);
    check("mid_pending", 32'(pending), 0);
    q.delete();
    e_wr = 1'b0; e_rd = '0; e_data = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_ready", 32'(alu_ready), 1);
    for (int i = 0; i < 50; i++) begin
      drive($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 1), 5'($urandom_range(0, 31)),
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom);
      cyc(a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
